gate_resp_checker: RTL and testbench

GATE_RESP_CHECKER -- requirements
Module: gate_resp_checker

---
 rtl/gate_resp_checker_if.sv | 30 +++
 rtl/gate_resp_checker.sv | 89 ++++++++
 tb/tb_gate_resp_checker.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/gate_resp_checker_if.sv
// Vector/handshake bundle between a gate-under-test harness (master) and
// gate_resp_checker (slave).
interface gate_resp_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [1:0]       op_sel;
  logic             vld;
  logic             a;
  logic             b;
  logic             y;
  logic             rdy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [3:0]       cov;
  logic             err_valid;
  logic [2:0]       first_fail;

  modport master (
    output start, op_sel, vld, a, b, y,
    input  rdy, done, pass, pass_cnt, fail_cnt, cov, err_valid, first_fail
  );

  modport slave (
    input  start, op_sel, vld, a, b, y,
    output rdy, done, pass, pass_cnt, fail_cnt, cov, err_valid, first_fail
  );
endinterface

// File: rtl/gate_resp_checker.sv
// Checks observed {a,b,y} vectors against a selected 2-input gate.
// A session ends once all four input combinations have been seen.
module gate_resp_checker #(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  gate_resp_checker_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] state;
  logic [1:0] op;
  logic       exp_y;
  logic       hit;
  logic [3:0] cov_next;

  always_comb begin
    exp_y = 1'b0;
    case (op)
      2'b00:   exp_y = bus.a & bus.b;
      2'b01:   exp_y = bus.a | bus.b;
      2'b10:   exp_y = bus.a ^ bus.b;
      default: exp_y = ~(bus.a & bus.b);
    endcase
    hit      = (bus.y == exp_y);
    cov_next = bus.cov | (4'b0001 << {bus.a, bus.b});
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      op             <= 2'b00;
      bus.rdy        <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.pass_cnt   <= '0;
      bus.fail_cnt   <= '0;
      bus.cov        <= 4'h0;
      bus.err_valid  <= 1'b0;
      bus.first_fail <= 3'b000;
    end else begin
      case (state)
        S_CHECK: begin
          if (bus.vld) begin
            if (hit) begin
              if (bus.pass_cnt != CNT_MAX) bus.pass_cnt <= bus.pass_cnt + CNT_W'(1);
            end else begin
              if (bus.fail_cnt != CNT_MAX) bus.fail_cnt <= bus.fail_cnt + CNT_W'(1);
              if (!bus.err_valid) begin
                bus.err_valid  <= 1'b1;
                bus.first_fail <= {bus.a, bus.b, bus.y};
              end
            end
            bus.cov <= cov_next;
            // The completing transfer's own result decides pass; counts never return to zero.
            if (cov_next == 4'hF) begin
              state    <= S_DONE;
              bus.rdy  <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= hit && (bus.fail_cnt == '0);
            end
          end
        end
        default: begin
          if (bus.start) begin
            state          <= S_CHECK;
            op             <= bus.op_sel;
            bus.rdy        <= 1'b1;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.pass_cnt   <= '0;
            bus.fail_cnt   <= '0;
            bus.cov        <= 4'h0;
            bus.err_valid  <= 1'b0;
            bus.first_fail <= 3'b000;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_resp_checker.sv
// Self-checking bench: two checkers (CNT_W=8 and CNT_W=2) share one stimulus
// stream and are compared every cycle against a session-level model.
module tb_gate_resp_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op_sel;
  logic       vld;
  logic       a;
  logic       b;
  logic       y;

  int checks   = 0;
  int failures = 0;

  gate_resp_checker_if #(.CNT_W(8)) bus8 ();
  gate_resp_checker_if #(.CNT_W(2)) bus2 ();

  gate_resp_checker #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  gate_resp_checker #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  assign bus8.start = start;  assign bus2.start = start;
  assign bus8.op_sel = op_sel; assign bus2.op_sel = op_sel;
  assign bus8.vld = vld;      assign bus2.vld = vld;
  assign bus8.a = a;          assign bus2.a = a;
  assign bus8.b = b;          assign bus2.b = b;
  assign bus8.y = y;          assign bus2.y = y;

  always #5 clk = ~clk;

  // Reference model: session flags plus unbounded counts, saturated on compare.
  bit       m_active;
  bit       m_done;
  int       m_op;
  int       m_pass;
  int       m_fail;
  bit [3:0] m_seen;
  bit       m_err;
  bit [2:0] m_first;

  function automatic bit gate(input int op, input bit ga, input bit gb);
    case (op)
      0:       return ga & gb;
      1:       return ga | gb;
      2:       return ga ^ gb;
      default: return !(ga & gb);
    endcase
  endfunction

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_clear();
    m_pass  = 0;
    m_fail  = 0;
    m_seen  = 4'h0;
    m_err   = 1'b0;
    m_first = 3'b000;
    m_done  = 1'b0;
  endtask

  task automatic model_update();
    if (rst) begin
      model_clear();
      m_active = 1'b0;
      m_op     = 0;
    end else if (!m_active) begin
      if (start) begin
        model_clear();
        m_active = 1'b1;
        m_op     = int'(op_sel);
      end
    end else if (vld) begin
      if (y == gate(m_op, a, b)) m_pass++;
      else begin
        m_fail++;
        if (!m_err) begin
          m_err   = 1'b1;
          m_first = {a, b, y};
        end
      end
      m_seen[{a, b}] = 1'b1;
      if (m_seen == 4'hF) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit pass_exp;
    pass_exp = m_done && (m_fail == 0);
    check("ctl8", {28'd0, bus8.rdy, bus8.done, bus8.pass, bus8.err_valid},
          {28'd0, m_active, m_done, pass_exp, m_err});
    check("cov8", {25'd0, bus8.cov, bus8.first_fail}, {25'd0, m_seen, m_first});
    check("cnt8", {16'd0, bus8.pass_cnt, bus8.fail_cnt},
          {16'd0, 8'(sat(m_pass, 8)), 8'(sat(m_fail, 8))});
    check("ctl2", {28'd0, bus2.rdy, bus2.done, bus2.pass, bus2.err_valid},
          {28'd0, m_active, m_done, pass_exp, m_err});
    check("cov2", {25'd0, bus2.cov, bus2.first_fail}, {25'd0, m_seen, m_first});
    check("cnt2", {28'd0, bus2.pass_cnt, bus2.fail_cnt},
          {28'd0, 2'(sat(m_pass, 2)), 2'(sat(m_fail, 2))});
  endtask

  // Drive one cycle of inputs, advance model and DUT, compare on the falling edge.
  task automatic step(input bit r, input bit s, input bit [1:0] op,
                      input bit v, input bit ia, input bit ib, input bit iy);
    rst = r; start = s; op_sel = op; vld = v; a = ia; b = ib; y = iy;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic vec(input bit ia, input bit ib, input bit iy);
    step(1'b0, 1'b0, 2'b00, 1'b1, ia, ib, iy);
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic open_session(input bit [1:0] op);
    step(1'b0, 1'b1, op, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m_active = 1'b0;
    m_op     = 0;
    model_clear();

    // Reset, with start and vld asserted alongside it.
    step(1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_rdy", {31'd0, bus8.rdy}, 32'd0);
    check("rst_cnt", {24'd0, bus8.pass_cnt}, 32'd0);

    // vld in IDLE is ignored.
    vec(1'b0, 1'b0, 1'b0);
    check("idle_vld_cov", {28'd0, bus8.cov}, 32'd0);

    // AND, all correct.
    open_session(2'b00);
    vec(0, 0, 0); vec(0, 1, 0); vec(1, 0, 0); vec(1, 1, 1);
    check("and_done", {29'd0, bus8.done, bus8.pass, bus8.rdy}, 32'b110);
    check("and_cnt", {16'd0, bus8.pass_cnt, bus8.fail_cnt}, {16'd0, 8'd4, 8'd0});
    check("and_cov", {27'd0, bus8.cov, bus8.err_valid}, {27'd0, 4'hF, 1'b0});

    // vld in DONE is ignored; outputs frozen.
    vec(0, 0, 1);
    check("done_vld", {24'd0, bus8.fail_cnt}, 32'd0);

    // XOR with a faulty (1,1) response.
    open_session(2'b10);
    vec(0, 0, 0); vec(0, 1, 1); vec(1, 0, 1); vec(1, 1, 1);
    check("xor_pass", {30'd0, bus8.done, bus8.pass}, 32'b10);
    check("xor_cnt", {16'd0, bus8.pass_cnt, bus8.fail_cnt}, {16'd0, 8'd3, 8'd1});
    check("xor_ff", {28'd0, bus8.err_valid, bus8.first_fail}, {28'd0, 1'b1, 3'b111});

    // OR with a repeated combination; pass_cnt saturates on the narrow instance.
    open_session(2'b01);
    vec(0, 0, 0); vec(0, 0, 0); vec(1, 1, 1); vec(0, 1, 1);
    check("or_not_done", {31'd0, bus8.done}, 32'd0);
    vec(1, 0, 1);
    check("or_done", {30'd0, bus8.done, bus8.pass}, 32'b11);
    check("or_cnt8", {24'd0, bus8.pass_cnt}, 32'd5);
    check("or_cnt2", {30'd0, bus2.pass_cnt}, 32'd3);
    check("or_cov", {28'd0, bus8.cov}, 32'hF);

    // NAND from DONE; a start during CHECK must not relatch op or clear counts.
    open_session(2'b11);
    vec(0, 0, 1);
    step(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    vec(1, 0, 1); vec(1, 1, 0);
    check("nand_done", {30'd0, bus8.done, bus8.pass}, 32'b11);
    check("nand_cnt", {16'd0, bus8.pass_cnt, bus8.fail_cnt}, {16'd0, 8'd4, 8'd0});

    // Reset mid-session after two transfers, with a vld in the reset cycle.
    open_session(2'b00);
    vec(0, 0, 0); vec(1, 1, 0);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    check("mid_rst", {20'd0, bus8.pass_cnt, bus8.cov}, 32'd0);
    check("mid_rst_flags", {28'd0, bus8.rdy, bus8.done, bus8.err_valid, bus8.pass}, 32'd0);

    // Five mismatches before coverage completes: narrow fail_cnt stops at 3.
    open_session(2'b00);
    repeat (5) vec(0, 0, 1);
    check("sat_fail2", {30'd0, bus2.fail_cnt}, 32'd3);
    check("sat_fail8", {24'd0, bus8.fail_cnt}, 32'd5);
    check("sat_first", {29'd0, bus2.first_fail}, 32'b001);
    vec(0, 1, 0); vec(1, 0, 0); vec(1, 1, 1);
    check("sat_done", {30'd0, bus2.done, bus2.pass}, 32'b10);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bit r, s, v, ia, ib, iy;
      bit [1:0] op;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 7) == 0);
      op = 2'($urandom_range(0, 3));
      v  = ($urandom_range(0, 3) != 0);
      ia = 1'($urandom_range(0, 1));
      ib = 1'($urandom_range(0, 1));
      iy = gate(int'(op_sel), ia, ib);
      iy = gate(m_op, ia, ib) ^ ($urandom_range(0, 4) == 0);
      step(r, s, op, v, ia, ib, iy);
    end

    idle_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
